// File: rtl/ysyx_23060203_mem_arb.sv
// Two-master (IFU read-only, LSU read/write) to one-slave memory arbiter, round-robin on ties.
// Latency: grant registered in IDLE, mem request one cycle after sampling; min 3 cycles per transaction.
// Backpressure: grant held through slave req stall and owner rsp stall; non-owner sees ready/valid 0.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   ifu_req_* / ifu_rsp_*   : IFU fetch request (addr) and response (rdata)
//   lsu_req_* / lsu_rsp_*   : LSU load/store request (wen, func, addr, wdata) and response (rdata)
//   mem_req_* / mem_rsp_*   : shared slave port
//   grant_lsu               : current or last owner (1 = LSU)
module ysyx_23060203_mem_arb (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_rsp_valid,
    input  logic        ifu_rsp_ready,
    output logic [31:0] ifu_rsp_rdata,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_wen,
    input  logic [2:0]  lsu_req_func,
    input  logic [31:0] lsu_req_addr,
    input  logic [31:0] lsu_req_wdata,
    output logic        lsu_rsp_valid,
    input  logic        lsu_rsp_ready,
    output logic [31:0] lsu_rsp_rdata,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [2:0]  mem_req_func,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_rdata,

    output logic        grant_lsu
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;           // 0 = IFU, 1 = LSU
    logic   last_owner_q, last_owner_d; // most recent grant, drives tie-break

    // Owner-selected handshake inputs; used by both the FSM and the output muxes.
    logic owner_req_valid;
    logic owner_rsp_ready;

    assign owner_req_valid = owner_q ? lsu_req_valid : ifu_req_valid;
    assign owner_rsp_ready = owner_q ? lsu_rsp_ready : ifu_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;       // IFU wins the first tie
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            S_IDLE: begin
                if (ifu_req_valid && lsu_req_valid) begin
                    owner_d      = ~last_owner_q;
                    last_owner_d = ~last_owner_q;
                    state_d      = S_REQ;
                end else if (ifu_req_valid) begin
                    owner_d      = 1'b0;
                    last_owner_d = 1'b0;
                    state_d      = S_REQ;
                end else if (lsu_req_valid) begin
                    owner_d      = 1'b1;
                    last_owner_d = 1'b1;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                // Owner dropping valid simply keeps the grant parked here.
                if (owner_req_valid && mem_req_ready) state_d = S_RSP;
            end
            S_RSP: begin
                if (mem_rsp_valid && owner_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are muxed by owner at all times; only the handshake
    // signals are state-qualified, so nothing from mem_rsp_* reaches mem_req_valid.
    always_comb begin
        mem_req_valid = 1'b0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_rsp_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        mem_req_wen   = owner_q & lsu_req_wen;
        mem_req_func  = owner_q ? lsu_req_func  : 3'b010;
        mem_req_addr  = owner_q ? lsu_req_addr  : ifu_req_addr;
        mem_req_wdata = owner_q ? lsu_req_wdata : 32'h0;
        case (state_q)
            S_REQ: begin
                mem_req_valid = owner_req_valid;
                if (owner_q) lsu_req_ready = mem_req_ready;
                else         ifu_req_ready = mem_req_ready;
            end
            S_RSP: begin
                mem_rsp_ready = owner_rsp_ready;
                if (owner_q) lsu_rsp_valid = mem_rsp_valid;
                else         ifu_rsp_valid = mem_rsp_valid;
            end
            default: ;
        endcase
    end

    assign ifu_rsp_rdata = mem_rsp_rdata;
    assign lsu_rsp_rdata = mem_rsp_rdata;
    assign grant_lsu     = owner_q;

endmodule
